wb_flush_ctrl: RTL and testbench

- Flush and redirect sequencer placed behind the writeback stage.
- Takes the per-cycle flush requests that WB raises (exception, ertn, refetch, icache-op, idle) and arbitrates them to a single winner.
- Kills the pipeline, computes the redirect PC, and hands the PC to fetch over a valid/ready handshake.
- Holds fetch stalled for long-latency events: icache maintenance completion and IDLE wake-up on interrupt.

---
 rtl/wb_flush_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_wb_flush_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_flush_ctrl.sv
// ---------------------------------------------------------------------------
// wb_flush_ctrl
//
// Flush and redirect sequencer behind the writeback stage. Arbitrates the
// per-cycle WB flush requests to one winner, kills the pipeline, computes the
// redirect PC and hands it to fetch over a valid/ready handshake. Fetch is held
// stalled while waiting for icache maintenance to finish or for an interrupt
// to wake the core from IDLE.
//
// Optional feature: define WB_FLUSH_CNT_EN to build a 32-bit counter of
// accepted flushes on flush_cnt; without it flush_cnt is tied to zero.
//
// Parameters
//   PC_INC          byte increment added to ws_pc for refetch/icacop/idle
//   ICACOP_TIMEOUT  max cycles in ICACOP_WAIT before a forced exit (1..255)
//
// Ports
//   clk, resetn      clock (rising edge) and asynchronous active-low reset
//   excp_flush       exception flush request       (priority 1, highest)
//   ertn_flush       ertn flush request            (priority 2)
//   icacop_flush     icache-op flush request       (priority 3)
//   idle_flush       idle instruction request      (priority 4)
//   refetch_flush    refetch request               (priority 5, lowest)
//   excp_tlbrefill   exception is a TLB refill (selects csr_tlbrentry)
//   ws_pc            PC of the WB instruction
//   csr_eentry       general exception entry
//   csr_tlbrentry    TLB refill entry
//   csr_era          ertn return address
//   has_int          pending enabled interrupt (wakes IDLE_WAIT)
//   icacop_done      icache op complete, one-cycle pulse
//   redirect_ready   fetch accepts the redirect
//   flush_out        combinational pipeline kill, only in RUN
//   redirect_valid   redirect PC valid (REDIR state)
//   redirect_pc      fetch target, stable until accepted
//   fetch_stall      fetch must not issue (any non-RUN state)
//   busy             state is not RUN
//   flush_cnt        count of accepted flushes (see WB_FLUSH_CNT_EN)
// ---------------------------------------------------------------------------
module wb_flush_ctrl #(
    parameter logic [31:0] PC_INC         = 32'd4,
    parameter int          ICACOP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        excp_flush,
    input  logic        ertn_flush,
    input  logic        refetch_flush,
    input  logic        icacop_flush,
    input  logic        idle_flush,
    input  logic        excp_tlbrefill,
    input  logic [31:0] ws_pc,
    input  logic [31:0] csr_eentry,
    input  logic [31:0] csr_tlbrentry,
    input  logic [31:0] csr_era,
    input  logic        has_int,
    input  logic        icacop_done,
    input  logic        redirect_ready,
    output logic        flush_out,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        fetch_stall,
    output logic        busy,
    output logic [31:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_REDIR,
        ST_ICACOP_WAIT,
        ST_IDLE_WAIT
    } state_e;

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_EXCP,
        SRC_ERTN,
        SRC_ICACOP,
        SRC_IDLE,
        SRC_REFETCH
    } src_e;

    // Counter value on which the forced exit from ICACOP_WAIT happens; the
    // counter starts at 0 on entry, so this gives exactly ICACOP_TIMEOUT
    // cycles of waiting.
    localparam logic [7:0] TMO_LAST = 8'(ICACOP_TIMEOUT - 1);

    state_e      state;
    src_e        win;
    logic [31:0] target;
    logic [7:0]  tmo_cnt;

    // -----------------------------------------------------------------------
    // Fixed-priority arbitration and target selection. Losing requests are
    // simply dropped; WB will not hold them once the pipeline is killed.
    // -----------------------------------------------------------------------
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        win    = SRC_NONE;
        target = ws_pc + PC_INC;
        if (excp_flush) begin
            win    = SRC_EXCP;
            target = excp_tlbrefill ? csr_tlbrentry : csr_eentry;
        end else if (ertn_flush) begin
            win    = SRC_ERTN;
            target = csr_era;
        end else if (icacop_flush) begin
            win = SRC_ICACOP;
        end else if (idle_flush) begin
            win = SRC_IDLE;
        end else if (refetch_flush) begin
            win = SRC_REFETCH;
        end
    end

    // Requests are only honoured in RUN; anything arriving while a flush is
    // already in progress is ignored and must not kill the pipeline again.
    assign flush_out = (state == ST_RUN) && (win != SRC_NONE);

    // -----------------------------------------------------------------------
    // Sequencer. redirect_valid, fetch_stall and busy are registered next to
    // the state so they come straight from flops.
    // -----------------------------------------------------------------------
    // NOTE: all state is updated with non-blocking assignments so every flop
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= ST_RUN;
            redirect_pc    <= '0;
            tmo_cnt        <= '0;
            redirect_valid <= 1'b0;
            fetch_stall    <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (win != SRC_NONE) begin
                        // Target is captured on the accept edge and then held
                        // untouched until fetch takes it.
                        redirect_pc <= target;
                        fetch_stall <= 1'b1;
                        busy        <= 1'b1;
                        case (win)
                            SRC_ICACOP: begin
                                state   <= ST_ICACOP_WAIT;
                                tmo_cnt <= '0;
                            end
                            SRC_IDLE: begin
                                state <= ST_IDLE_WAIT;
                            end
                            default: begin
                                state          <= ST_REDIR;
                                redirect_valid <= 1'b1;
                            end
                        endcase
                    end
                end

                ST_ICACOP_WAIT: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    // A done pulse coinciding with the timeout is one exit.
                    if (icacop_done || (tmo_cnt == TMO_LAST)) begin
                        state          <= ST_REDIR;
                        redirect_valid <= 1'b1;
                    end
                end

                ST_IDLE_WAIT: begin
                    if (has_int) begin
                        state          <= ST_REDIR;
                        redirect_valid <= 1'b1;
                    end
                end

                ST_REDIR: begin
                    // No timeout: the redirect stays offered until accepted.
                    if (redirect_valid && redirect_ready) begin
                        state          <= ST_RUN;
                        redirect_valid <= 1'b0;
                        fetch_stall    <= 1'b0;
                        busy           <= 1'b0;
                    end
                end

                default: begin
                    state          <= ST_RUN;
                    redirect_valid <= 1'b0;
                    fetch_stall    <= 1'b0;
                    busy           <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Accepted-flush counter (optional).
    // -----------------------------------------------------------------------
`ifdef WB_FLUSH_CNT_EN
    logic [31:0] cnt_q;

    // flush_out is exactly "RUN with a request", i.e. an accepted flush.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (flush_out) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign flush_cnt = cnt_q;
`else
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_flush_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wb_flush_ctrl
//
// Directed bench for wb_flush_ctrl. A behavioural model tracks "is a redirect
// pending", "what are we waiting for and how long is left" and the captured
// target; a compare process checks every DUT output against it on each
// falling edge. Literal expectations from hand-worked scenarios pin the model.
// ---------------------------------------------------------------------------
module tb_wb_flush_ctrl;

    localparam int TMO = 8;
`ifdef WB_FLUSH_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic        excp_flush, ertn_flush, refetch_flush, icacop_flush, idle_flush;
    logic        excp_tlbrefill;
    logic [31:0] ws_pc, csr_eentry, csr_tlbrentry, csr_era;
    logic        has_int, icacop_done, redirect_ready;
    logic        flush_out, redirect_valid, fetch_stall, busy;
    logic [31:0] redirect_pc, flush_cnt;

    wb_flush_ctrl #(
        .PC_INC         (32'd4),
        .ICACOP_TIMEOUT (TMO)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .excp_flush     (excp_flush),
        .ertn_flush     (ertn_flush),
        .refetch_flush  (refetch_flush),
        .icacop_flush   (icacop_flush),
        .idle_flush     (idle_flush),
        .excp_tlbrefill (excp_tlbrefill),
        .ws_pc          (ws_pc),
        .csr_eentry     (csr_eentry),
        .csr_tlbrentry  (csr_tlbrentry),
        .csr_era        (csr_era),
        .has_int        (has_int),
        .icacop_done    (icacop_done),
        .redirect_ready (redirect_ready),
        .flush_out      (flush_out),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_stall    (fetch_stall),
        .busy           (busy),
        .flush_cnt      (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Behavioural model
    // ---------------------------------------------------------------------
    logic        any_req;
    assign any_req = excp_flush | ertn_flush | refetch_flush | icacop_flush | idle_flush;

    bit          m_redir;       // a redirect is being offered to fetch
    bit          m_wait_cache;  // waiting for icache op
    bit          m_wait_int;    // waiting for interrupt
    int          m_left;        // cycles of icache wait still allowed
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_redir      <= 1'b0;
            m_wait_cache <= 1'b0;
            m_wait_int   <= 1'b0;
            m_left       <= 0;
            m_pc         <= '0;
            m_cnt        <= '0;
        end else if (m_redir) begin
            if (redirect_ready) m_redir <= 1'b0;
        end else if (m_wait_cache) begin
            m_left <= m_left - 1;
            if (icacop_done || (m_left - 1 == 0)) begin
                m_wait_cache <= 1'b0;
                m_redir      <= 1'b1;
            end
        end else if (m_wait_int) begin
            if (has_int) begin
                m_wait_int <= 1'b0;
                m_redir    <= 1'b1;
            end
        end else if (any_req) begin
            if (CNT_ON) m_cnt <= m_cnt + 32'd1;
            if (excp_flush) begin
                m_pc    <= excp_tlbrefill ? csr_tlbrentry : csr_eentry;
                m_redir <= 1'b1;
            end else if (ertn_flush) begin
                m_pc    <= csr_era;
                m_redir <= 1'b1;
            end else if (icacop_flush) begin
                m_pc         <= ws_pc + 32'd4;
                m_wait_cache <= 1'b1;
                m_left       <= TMO;
            end else if (idle_flush) begin
                m_pc       <= ws_pc + 32'd4;
                m_wait_int <= 1'b1;
            end else begin
                m_pc    <= ws_pc + 32'd4;
                m_redir <= 1'b1;
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            automatic bit m_busy = m_redir | m_wait_cache | m_wait_int;
            check("flush_out",      32'(flush_out),      32'(!m_busy && any_req));
            check("redirect_valid", 32'(redirect_valid), 32'(m_redir));
            check("fetch_stall",    32'(fetch_stall),    32'(m_busy));
            check("busy",           32'(busy),           32'(m_busy));
            check("redirect_pc",    redirect_pc,         m_pc);
            check("flush_cnt",      flush_cnt,           m_cnt);
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers: inputs change just after a rising edge only.
    // ---------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_req();
        excp_flush    = 1'b0;
        ertn_flush    = 1'b0;
        refetch_flush = 1'b0;
        icacop_flush  = 1'b0;
        idle_flush    = 1'b0;
    endtask

    task automatic accept();
        tick();
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        resetn         = 1'b0;
        clr_req();
        excp_tlbrefill = 1'b0;
        ws_pc          = 32'h1C000000;
        csr_eentry     = 32'h1C008000;
        csr_tlbrentry  = 32'h1C00F000;
        csr_era        = 32'h1C00A000;
        has_int        = 1'b0;
        icacop_done    = 1'b0;
        redirect_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_rv",    32'(redirect_valid), 32'd0);
        check("rst_stall", 32'(fetch_stall), 32'd0);
        check("rst_pc",    redirect_pc, 32'd0);
        check("rst_cnt",   flush_cnt, 32'd0);
        tick();
        resetn = 1'b1;
        cmp_en = 1'b1;

        // 1) Plain exception, 1-cycle latency to redirect_valid
        tick();
        excp_flush = 1'b1;
        @(negedge clk);
        check("t1_flush_out", 32'(flush_out), 32'd1);
        tick();
        clr_req();
        @(negedge clk);
        check("t1_rv", 32'(redirect_valid), 32'd1);
        check("t1_pc", redirect_pc, 32'h1C008000);
        accept();
        @(negedge clk);
        check("t1_busy_after", 32'(busy), 32'd0);

        // 2) excp+ertn+refetch together, TLB refill wins
        tick();
        excp_flush     = 1'b1;
        ertn_flush     = 1'b1;
        refetch_flush  = 1'b1;
        excp_tlbrefill = 1'b1;
        tick();
        clr_req();
        excp_tlbrefill = 1'b0;
        @(negedge clk);
        check("t2_pc",  redirect_pc, 32'h1C00F000);
        check("t2_cnt", flush_cnt, CNT_ON ? 32'd2 : 32'd0);
        accept();

        // 3) Idle, interrupt after 20 cycles
        tick();
        ws_pc      = 32'h1C000100;
        idle_flush = 1'b1;
        tick();
        clr_req();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t3_stall", 32'(fetch_stall), 32'd1);
        end
        tick();
        has_int = 1'b1;
        @(negedge clk);
        check("t3_rv_early", 32'(redirect_valid), 32'd0);
        tick();
        @(negedge clk);
        check("t3_rv", 32'(redirect_valid), 32'd1);
        check("t3_pc", redirect_pc, 32'h1C000104);
        tick();
        has_int = 1'b0;
        accept();

        // 4) Icache op timeout: REDIR exactly TMO cycles after entry
        tick();
        ws_pc        = 32'h1C000200;
        icacop_flush = 1'b1;
        tick();
        clr_req();
        k = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (redirect_valid) break;
            k++;
        end
        check("t4_wait_cycles", 32'(k), 32'd8);
        check("t4_pc", redirect_pc, 32'h1C000204);
        accept();

        // 4b) Icache op completes early
        tick();
        ws_pc        = 32'h1C000400;
        icacop_flush = 1'b1;
        tick();
        clr_req();
        tick();
        tick();
        icacop_done = 1'b1;
        tick();
        icacop_done = 1'b0;
        @(negedge clk);
        check("t4b_rv", 32'(redirect_valid), 32'd1);
        check("t4b_pc", redirect_pc, 32'h1C000404);
        accept();

        // 4c) Done pulse coincides with the timeout cycle
        tick();
        ws_pc        = 32'h1C000500;
        icacop_flush = 1'b1;
        tick();
        clr_req();
        repeat (7) tick();
        icacop_done = 1'b1;
        tick();
        icacop_done = 1'b0;
        @(negedge clk);
        check("t4c_rv", 32'(redirect_valid), 32'd1);
        accept();
        @(negedge clk);
        check("t4c_busy_after", 32'(busy), 32'd0);

        // 5) Refetch at PC wrap, redirect held 5 cycles, refetch pulsed
        tick();
        ws_pc         = 32'hFFFFFFFC;
        refetch_flush = 1'b1;
        tick();
        clr_req();
        @(negedge clk);
        check("t5_pc_wrap", redirect_pc, 32'h00000000);
        tick();
        ws_pc         = 32'h1C000600;
        refetch_flush = 1'b1;
        @(negedge clk);
        check("t5_flush_out_ignored", 32'(flush_out), 32'd0);
        tick();
        clr_req();
        repeat (2) tick();
        @(negedge clk);
        check("t5_pc_stable", redirect_pc, 32'h00000000);
        check("t5_rv_held",   32'(redirect_valid), 32'd1);
        accept();
        @(negedge clk);
        check("t5_rv_after", 32'(redirect_valid), 32'd0);
        check("t5_cnt",      flush_cnt, CNT_ON ? 32'd7 : 32'd0);

        // 6) Reset asserted mid IDLE_WAIT takes effect immediately
        tick();
        ws_pc      = 32'h1C000700;
        idle_flush = 1'b1;
        tick();
        clr_req();
        repeat (3) tick();
        resetn = 1'b0;
        #1;
        check("t6_busy",  32'(busy), 32'd0);
        check("t6_stall", 32'(fetch_stall), 32'd0);
        check("t6_rv",    32'(redirect_valid), 32'd0);
        check("t6_cnt",   flush_cnt, 32'd0);
        check("t6_pc",    redirect_pc, 32'd0);
        repeat (2) tick();
        resetn = 1'b1;
        tick();

        // After reset, a fresh ertn still works
        tick();
        ertn_flush = 1'b1;
        tick();
        clr_req();
        @(negedge clk);
        check("t7_pc", redirect_pc, 32'h1C00A000);
        accept();
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
